// File: rtl/econv_enc_322_if.sv
// Handshake bundle for the rate-2/3 encoder: data symbols in, code symbols and
// frame status out.
interface econv_enc_322_if;
  logic [1:0] Dx_in;
  logic       din_valid;
  logic       din_ready;
  logic [2:0] Rx_out;
  logic       tx_valid;
  logic       tx_ready;
  logic       seq_ready;
  logic       frame_done;
  logic       busy;

  modport master (
    output Dx_in, din_valid, tx_ready,
    input  din_ready, Rx_out, tx_valid, seq_ready, frame_done, busy
  );

  modport slave (
    input  Dx_in, din_valid, tx_ready,
    output din_ready, Rx_out, tx_valid, seq_ready, frame_done, busy
  );
endinterface

// File: rtl/econv_enc_322.sv
// Rate-2/3, 8-state (3,2,2) convolutional encoder. Frames of L data symbols are
// followed by two zero tail symbols that flush the memory back to state 0.
module econv_enc_322 #(
  parameter int unsigned L  = 32,
  parameter int unsigned CW = $clog2(L + 1)
) (
  input logic            clock,
  input logic            reset,
  econv_enc_322_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  localparam logic [CW-1:0] LastCnt = CW'(L);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tcnt_q, tcnt_d;
  logic          a1_q, a2_q, b1_q;
  logic [2:0]    rx_q;
  logic          tx_valid_q, seq_q, done_q;

  logic          advance, din_ready, fire;
  logic [1:0]    u;
  logic [2:0]    code;

  // A symbol can be produced only when the output slot is empty or draining.
  assign advance   = !tx_valid_q || bus.tx_ready;
  assign din_ready = (state_q != StTail) && advance;
  assign fire      = (state_q == StTail) ? advance : (bus.din_valid && din_ready);
  assign u         = (state_q == StTail) ? 2'b00 : bus.Dx_in;

  assign code = {u[1] ^ a1_q ^ b1_q,
                 u[0] ^ a1_q ^ a2_q,
                 u[1] ^ u[0] ^ a2_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    if (fire) begin
      unique case (state_q)
        StIdle: begin
          if (L == 1) begin
            state_d = StTail;
            tcnt_d  = 1'b0;
          end else begin
            state_d = StData;
            cnt_d   = CW'(1);
          end
        end
        StData: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LastCnt) begin
            state_d = StTail;
            tcnt_d  = 1'b0;
          end
        end
        StTail: begin
          tcnt_d = 1'b1;
          if (tcnt_q) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tcnt_q     <= 1'b0;
      a1_q       <= 1'b0;
      a2_q       <= 1'b0;
      b1_q       <= 1'b0;
      rx_q       <= 3'b000;
      tx_valid_q <= 1'b0;
      seq_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      if (fire) begin
        rx_q       <= code;
        tx_valid_q <= 1'b1;
        seq_q      <= (state_q == StIdle);
        done_q     <= (state_q == StTail) && tcnt_q;
        a2_q       <= a1_q;
        a1_q       <= u[1];
        b1_q       <= u[0];
      end else if (bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.Rx_out     = rx_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.seq_ready  = seq_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = (state_q != StIdle);

endmodule
